// File: rtl/optical_tx_framer.sv
// Multi-channel GTP transmit framer: bonding sequences, start marker, comma-tagged PRBS-31 payload.
// Optional error injection on channel 0 is built when OPT_TX_ERRINJ_EN is defined.
module optical_tx_framer #(
    parameter int unsigned NCH            = 2,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned BOND_SPACING   = 32,
    parameter int unsigned BOND_COUNT     = 255,
    parameter int unsigned RESTART_PERIOD = 40000000,
    parameter logic [30:0] PRBS_SEED      = 31'h7FFFFFFF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NCH-1:0]          gtp_ready,
    input  logic                    inj_err,
    output logic [NCH*DATA_W-1:0]   tx_data,
    output logic [NCH*DATA_W/8-1:0] tx_iskchar,
    output logic                    bond_done,
    output logic                    restart,
    output logic [1:0]              state
);

    localparam int unsigned KW = DATA_W / 8;
    localparam int unsigned PW = DATA_W - 16;
    localparam int unsigned FW = (BOND_SPACING > 2) ? $clog2(BOND_SPACING) : 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(BOND_SPACING - 1);
    localparam logic [7:0]    SEQ_LAST   = 8'(BOND_COUNT - 1);
    localparam logic [31:0]   RCNT_LAST  = 32'(RESTART_PERIOD - 1);
    localparam logic [31:0]   BOND_WORD  = 32'h1CFEFBDC;

    typedef enum logic [1:0] {
        StWaitRdy = 2'd0,
        StBond    = 2'd1,
        StStart   = 2'd2,
        StRun     = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [FW-1:0]                frame_q, frame_d;
    logic [7:0]                   seq_q, seq_d;
    logic [31:0]                  rcnt_q, rcnt_d;
    logic [NCH-1:0][30:0]         lfsr_q, lfsr_d, seeds;
    logic [NCH-1:0][DATA_W-1:0]   data_q, data_d;
    logic [NCH-1:0][KW-1:0]       k_q, k_d;
    logic                         bond_done_q, bond_done_d;
    logic                         restart_q, restart_d;
    logic [PW+30:0]               step;

`ifdef OPT_TX_ERRINJ_EN
    logic err_pend_q, err_pend_d;
`else
    logic unused_inj_err;
    assign unused_inj_err = inj_err;
`endif

    // Advance one PRBS-31 (x^31 + x^28 + 1) LFSR by PW bits; returns {bits MSB-first, new state}.
    function automatic logic [PW+30:0] prbs_step(input logic [30:0] s_in);
        logic [30:0]   s;
        logic [PW-1:0] bits;
        logic          nb;
        s    = s_in;
        bits = '0;
        for (int b = 0; b < PW; b++) begin
            nb              = s[30] ^ s[27];
            bits[PW-1-b]    = nb;
            s               = {s[29:0], nb};
        end
        return {bits, s};
    endfunction

    always_comb begin
        seeds = '0;
        for (int i = 0; i < NCH; i++) begin
            seeds[i] = PRBS_SEED ^ 31'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        seq_d     = seq_q;
        rcnt_d    = rcnt_q;
        lfsr_d    = lfsr_q;
        data_d    = '0;
        k_d       = '0;
        restart_d = 1'b0;
        step      = '0;

        unique case (state_q)
            StWaitRdy: state_d = StBond;
            StBond: begin
                if (frame_q == FRAME_LAST) begin
                    frame_d = '0;
                    seq_d   = seq_q + 8'd1;
                    for (int i = 0; i < NCH; i++) begin
                        data_d[i][31:0] = BOND_WORD;
                        k_d[i][3:0]     = 4'hF;
                    end
                    if (seq_q == SEQ_LAST) begin
                        state_d = StStart;
                    end
                end else begin
                    frame_d = frame_q + 1'b1;
                end
            end
            StStart: begin
                for (int i = 0; i < NCH; i++) begin
                    data_d[i] = {KW{8'hFC}};
                    k_d[i]    = '1;
                end
                lfsr_d    = seeds;
                restart_d = 1'b1;
                rcnt_d    = '0;
                state_d   = StRun;
            end
            StRun: begin
                for (int i = 0; i < NCH; i++) begin
                    step      = prbs_step(lfsr_q[i]);
                    data_d[i] = {step[PW+30:31], 16'hBC50};
                    k_d[i]    = KW'(2'b11);
                    lfsr_d[i] = step[30:0];
                end
                rcnt_d = rcnt_q + 32'd1;
                if ((RESTART_PERIOD != 0) && (rcnt_q == RCNT_LAST)) begin
                    state_d = StStart;
                end
            end
            default: state_d = StWaitRdy;
        endcase

`ifdef OPT_TX_ERRINJ_EN
        // A pending flip lands on the first RUN word computed after the pulse.
        err_pend_d = err_pend_q;
        if (state_q == StRun) begin
            if (err_pend_q) begin
                data_d[0][16] = ~data_d[0][16];
                err_pend_d    = 1'b0;
            end
            if (inj_err) begin
                err_pend_d = 1'b1;
            end
        end
`endif

        if (reset || !(&gtp_ready)) begin
            state_d   = StWaitRdy;
            frame_d   = '0;
            seq_d     = '0;
            rcnt_d    = '0;
            data_d    = '0;
            k_d       = '0;
            restart_d = 1'b0;
`ifdef OPT_TX_ERRINJ_EN
            err_pend_d = 1'b0;
`endif
        end

        bond_done_d = (state_d == StStart) || (state_d == StRun);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StWaitRdy;
            frame_q     <= '0;
            seq_q       <= '0;
            rcnt_q      <= '0;
            lfsr_q      <= seeds;
            data_q      <= '0;
            k_q         <= '0;
            bond_done_q <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            seq_q       <= seq_d;
            rcnt_q      <= rcnt_d;
            lfsr_q      <= lfsr_d;
            data_q      <= data_d;
            k_q         <= k_d;
            bond_done_q <= bond_done_d;
            restart_q   <= restart_d;
        end
    end

`ifdef OPT_TX_ERRINJ_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            err_pend_q <= 1'b0;
        end else begin
            err_pend_q <= err_pend_d;
        end
    end
`endif

    assign tx_data    = data_q;
    assign tx_iskchar = k_q;
    assign bond_done  = bond_done_q;
    assign restart    = restart_q;
    assign state      = state_q;

endmodule

// File: tb/tb_optical_tx_framer.sv
// Directed bench for optical_tx_framer: bonding table, PRBS-31 reference model, restart,
// link drop and error-injection behaviour (expectation follows OPT_TX_ERRINJ_EN).
module tb_optical_tx_framer;

    localparam logic [63:0] BW = 64'h000000001CFEFBDC;
    localparam logic [63:0] MK = 64'hFCFCFCFCFCFCFCFC;
    localparam logic [63:0] FIRST0 = 64'h0000000E0000BC50;
    localparam logic [63:0] FIRST1 = 64'h0000001C0000BC50;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   gtp_ready;
    logic         inj_err;
    logic [127:0] tx_data;
    logic [15:0]  tx_iskchar;
    logic         bond_done;
    logic         restart;
    logic [1:0]   state;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0]  st;
        logic [63:0] word;
        logic [7:0]  k;
        logic        rs;
        logic        bd;
    } bvec_t;

    bvec_t       btab [14];
    logic [30:0] m_s [2];

    optical_tx_framer #(
        .NCH(2),
        .DATA_W(64),
        .BOND_SPACING(4),
        .BOND_COUNT(3),
        .RESTART_PERIOD(100),
        .PRBS_SEED(31'h7FFFFFFF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .gtp_ready(gtp_ready),
        .inj_err(inj_err),
        .tx_data(tx_data),
        .tx_iskchar(tx_iskchar),
        .bond_done(bond_done),
        .restart(restart),
        .state(state)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_word(input int ch, output logic [47:0] w);
        logic nb;
        w = '0;
        for (int b = 0; b < 48; b++) begin
            nb       = m_s[ch][30] ^ m_s[ch][27];
            w        = {w[46:0], nb};
            m_s[ch]  = {m_s[ch][29:0], nb};
        end
    endtask

    // Entry e is sampled e cycles after the first cycle with state == BOND.
    task automatic run_bond_table(input string tag);
        for (int e = 0; e < 14; e++) begin
            @(negedge clock);
            chk($sformatf("%s bond[%0d] data", tag, e), tx_data, {btab[e].word, btab[e].word});
            chk($sformatf("%s bond[%0d] isk", tag, e), 128'(tx_iskchar), 128'({btab[e].k, btab[e].k}));
            chk($sformatf("%s bond[%0d] st/rs/bd", tag, e), 128'({state, restart, bond_done}),
                128'({btab[e].st, btab[e].rs, btab[e].bd}));
        end
    endtask

    // Cycle c counts output cycles after the last marker seen in run_bond_table.
    task automatic run_loop(input string tag, input int ncyc, input int inj_at);
        logic [47:0]  w0, w1;
        logic [63:0]  e0, e1;
        logic [127:0] exp_d;
        logic [15:0]  exp_k;
        logic [1:0]   exp_st;
        logic         exp_rs;
        int           pos;
        m_s[0] = 31'h7FFFFFFF;
        m_s[1] = 31'h7FFFFFFE;
        for (int c = 1; c <= ncyc; c++) begin
            pos = c % 101;
            @(negedge clock);
            if (pos == 0) begin
                exp_d  = {MK, MK};
                exp_k  = 16'hFFFF;
                exp_st = 2'd3;
                exp_rs = 1'b1;
                m_s[0] = 31'h7FFFFFFF;
                m_s[1] = 31'h7FFFFFFE;
            end else begin
                model_word(0, w0);
                model_word(1, w1);
                e0 = {w0, 16'hBC50};
                e1 = {w1, 16'hBC50};
`ifdef OPT_TX_ERRINJ_EN
                if (c == inj_at + 2) e0[16] = ~e0[16];
`endif
                exp_d  = {e1, e0};
                exp_k  = 16'h0303;
                exp_st = (pos == 100) ? 2'd2 : 2'd3;
                exp_rs = 1'b0;
            end
            chk($sformatf("%s run[%0d] data", tag, c), tx_data, exp_d);
            chk($sformatf("%s run[%0d] isk", tag, c), 128'(tx_iskchar), 128'(exp_k));
            chk($sformatf("%s run[%0d] st/rs/bd", tag, c), 128'({state, restart, bond_done}),
                128'({exp_st, exp_rs, 1'b1}));
            if (pos == 1) begin
                chk($sformatf("%s first word ch0 c=%0d", tag, c), 128'(tx_data[63:0]), 128'(FIRST0));
                chk($sformatf("%s first word ch1 c=%0d", tag, c), 128'(tx_data[127:64]),
                    128'(FIRST1));
            end
            inj_err = (c == inj_at);
        end
        inj_err = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        gtp_ready = 2'b01;
        inj_err   = 1'b0;

        btab[0]  = '{2'd1, 64'h0, 8'h00, 1'b0, 1'b0};
        btab[1]  = '{2'd1, 64'h0, 8'h00, 1'b0, 1'b0};
        btab[2]  = '{2'd1, 64'h0, 8'h00, 1'b0, 1'b0};
        btab[3]  = '{2'd1, 64'h0, 8'h00, 1'b0, 1'b0};
        btab[4]  = '{2'd1, BW,    8'h0F, 1'b0, 1'b0};
        btab[5]  = '{2'd1, 64'h0, 8'h00, 1'b0, 1'b0};
        btab[6]  = '{2'd1, 64'h0, 8'h00, 1'b0, 1'b0};
        btab[7]  = '{2'd1, 64'h0, 8'h00, 1'b0, 1'b0};
        btab[8]  = '{2'd1, BW,    8'h0F, 1'b0, 1'b0};
        btab[9]  = '{2'd1, 64'h0, 8'h00, 1'b0, 1'b0};
        btab[10] = '{2'd1, 64'h0, 8'h00, 1'b0, 1'b0};
        btab[11] = '{2'd1, 64'h0, 8'h00, 1'b0, 1'b0};
        btab[12] = '{2'd2, BW,    8'h0F, 1'b0, 1'b1};
        btab[13] = '{2'd3, MK,    8'hFF, 1'b1, 1'b1};

        // Reset held with one channel not ready; inj_err toggling must be ignored.
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            chk($sformatf("reset[%0d] data", c), tx_data, 128'h0);
            chk($sformatf("reset[%0d] st/bd", c), 128'({state, bond_done, restart}), 128'h0);
            inj_err = c[0];
        end
        reset   = 1'b0;
        inj_err = 1'b0;

        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk($sformatf("notready[%0d] data", c), tx_data, 128'h0);
            chk($sformatf("notready[%0d] st/bd", c), 128'({state, bond_done}), 128'h0);
        end

        gtp_ready = 2'b11;
        run_bond_table("init");
        run_loop("init", 250, 30);

        // One-cycle drop of channel 1 readiness in the middle of RUN.
        gtp_ready = 2'b01;
        @(negedge clock);
        gtp_ready = 2'b11;
        chk("drop data", tx_data, 128'h0);
        chk("drop isk", 128'(tx_iskchar), 128'h0);
        chk("drop st/rs/bd", 128'({state, restart, bond_done}), 128'h0);

        run_bond_table("rebond");
        run_loop("rebond", 110, -10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/optical_tx_framer.md
Name: optical_tx_framer

Overview:
- Parametrised multi-channel transmit framer for the optical (GTP) links, running in the 40 MHz logic clock domain.
- Generates per-channel parallel TX words and K-char flags in four phases: channel-bonding sequences after transceiver reset-done, a start-of-sequence marker, then comma-tagged PRBS payload.
- Periodically restarts the PRBS with a fresh marker so a late-connecting receiver can lock.
- Output feeds the downstream clock-domain-crossing FIFOs and GTP wrapper; those are not part of this block.

Parameters:
- NCH, 2, number of TX channels.
- DATA_W, 64, bits per channel word; multiple of 8, at least 48.
- BOND_SPACING, 32, cycles between bonding sequences (2..256).
- BOND_COUNT, 255, number of bonding sequences sent before the marker (1..255).
- RESTART_PERIOD, 40000000, RUN cycles between PRBS restarts; 0 disables restart.
- PRBS_SEED, 31'h7FFFFFFF, PRBS-31 seed for channel 0; channel i uses PRBS_SEED ^ i. Must be nonzero for every channel.

Ports:
- clock  in  1  40 MHz logic clock.
- reset  in  1  synchronous, active-high reset.
- gtp_ready  in  NCH  per-channel transceiver reset-done.
- inj_err  in  1  one-cycle error-injection request (see Optional Feature).
- tx_data  out  NCH*DATA_W  channel i in bits [i*DATA_W +: DATA_W].
- tx_iskchar  out  NCH*DATA_W/8  bit k flags byte k of the corresponding channel as a K-char.
- bond_done  out  1  high from the START cycle onward.
- restart  out  1  one-cycle pulse coincident with each marker word on the output.
- state  out  2  0=WAIT_RDY, 1=BOND, 2=START, 3=RUN.

Behaviour:
- One FSM shared by all channels; each channel has its own PRBS-31 LFSR.
- All outputs are registered; a word appears on the output the cycle after its state/counter values.
- Reset values: tx_data 0, tx_iskchar 0, bond_done 0, restart 0, state WAIT_RDY, all counters 0.
- Any cycle with reset=1 or !(&gtp_ready):
  - next state is WAIT_RDY;
  - bond frame counter, bond sequence counter and restart counter clear;
  - output word is all-zero data with zero K flags.
- WAIT_RDY -> BOND once &gtp_ready is high.
- BOND:
  - Frame counter counts 0..BOND_SPACING-1 and wraps.
  - On the count BOND_SPACING-1, emit the bonding word: bytes[3:0] = 8'hDC, 8'hFB, 8'hFE, 8'h1C (byte3 = 8'h1C), upper bytes 0, iskchar low 4 bits set. The bonding-sequence count then increments.
  - All other BOND cycles emit zeros with zero K flags.
  - After BOND_COUNT sequences have been sent -> START.
- START: exactly one cycle.
  - Emit 8'hFC in every byte with all K flags set; restart pulses with this word.
  - Every LFSR is loaded with its seed.
  - Restart counter clears.
  - Next state RUN.
- RUN:
  - Word = {prbs[DATA_W-17:0], 16'hBC50}, iskchar = 2'b11 in the low bits, other bits 0.
  - Each LFSR (x^31 + x^28 + 1) advances DATA_W-16 bits per cycle; the output is the first DATA_W-16 bits generated after the seed, MSB first.
  - The restart counter increments each RUN cycle. When it reaches RESTART_PERIOD-1 (and RESTART_PERIOD != 0), the next state is START.
- BOND is never re-entered except through WAIT_RDY.
- Simultaneous events: loss of gtp_ready or reset overrides restart and START.
- inj_err arriving in a non-RUN state is ignored.

Optional Feature:
- Macro: OPT_TX_ERRINJ_EN.
- Defined: an inj_err pulse in RUN inverts bit 16 (PRBS LSB) of the next emitted word on channel 0 only. The LFSR state is unaffected. Multiple pulses queue at most one pending inversion.
- Undefined: inj_err is ignored and the output is bit-exact PRBS.

Test Plan:
- Reset with gtp_ready=2'b01 held 50 cycles -> state=0, tx_data all zeros, bond_done=0 throughout.
- NCH=2, BOND_SPACING=4, BOND_COUNT=3, gtp_ready=2'b11 -> bonding words with low 32 bits 32'h1CFEFBDC and iskchar 8'h0F on output cycles 4, 8, 12 after BOND entry; then an 8'hFC marker with iskchar 8'hFF and restart=1; then RUN.
- RUN check -> low 16 bits 16'hBC50 with iskchar 8'h03 every cycle; payload matches a reference PRBS-31 model seeded 31'h7FFFFFFF (ch0) and 31'h7FFFFFFE (ch1).
- RESTART_PERIOD=100 -> marker every 101 output cycles; the first PRBS word after each marker is identical to the first word after the initial marker.
- Drop gtp_ready[1] mid-RUN for 1 cycle -> zeros on output the next cycle, state=WAIT_RDY, then the full bonding sequence repeats (3 sequences).
- With OPT_TX_ERRINJ_EN, pulse inj_err in RUN -> exactly one channel-0 word with bit 16 flipped; channel 1 and the following words are unchanged. Without the macro, no difference from the model.
